memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_if.sv | 39 +++
 rtl/memory_access.sv | 131 +++++++++++++
 2 files changed

// File: rtl/memory_access_if.sv
// EX/MEM -> MEM/WB bus of the memory-access stage, plus the debug read port.
interface memory_access_if #(
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    inWB;
    logic [2:0]    inMEM;
    logic [2:0]    inLSType;
    logic [31:0]   inALUResult;
    logic [31:0]   inRegB;
    logic [4:0]    inRegF_wreg;
    logic          stop_debug;
    logic [AW-1:0] dbg_addr;

    logic [4:0]    outWB;
    logic [31:0]   outALUResult;
    logic [31:0]   outReadData;
    logic [4:0]    outRegF_wreg;
    logic [31:0]   outRegF_wd;
    logic          outMisaligned;
    logic [4:0]    MEM_rd;
    logic          MEM_regF_wr;
    logic [31:0]   dbg_data;

    modport slave (
        input  inWB, inMEM, inLSType, inALUResult, inRegB, inRegF_wreg,
               stop_debug, dbg_addr,
        output outWB, outALUResult, outReadData, outRegF_wreg, outRegF_wd,
               outMisaligned, MEM_rd, MEM_regF_wr, dbg_data
    );

    modport master (
        output inWB, inMEM, inLSType, inALUResult, inRegB, inRegF_wreg,
               stop_debug, dbg_addr,
        input  outWB, outALUResult, outReadData, outRegF_wreg, outRegF_wd,
               outMisaligned, MEM_rd, MEM_regF_wr, dbg_data
    );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: byte-lane data memory with B/H/W loads and stores,
// misalignment detection and the MEM/WB register, all clocked on the falling edge.
module memory_access_lane #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wrData,
    output logic [7:0]    rdData,
    input  logic [AW-1:0] dbgIdx,
    output logic [7:0]    dbgData
);
    logic [DEPTH-1:0][7:0] mem;

    // Memory is never cleared; a store caught under reset is simply dropped.
    always_ff @(negedge clk) begin
        if (rst && we) mem[idx] <= wrData;
    end

    assign rdData  = mem[idx];
    assign dbgData = mem[dbgIdx];
endmodule

module memory_access #(
    parameter int DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    memory_access_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = 4;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    logic [AW-1:0]          wordIdx;
    logic [1:0]             byteOff;
    logic                   memRead, memWrite;
    logic                   isB, isH, isW, isSigned;
    logic                   misaligned, wrEn;
    logic [LANES-1:0]       byteEn;
    logic [LANES-1:0][7:0]  wrData;
    logic [LANES-1:0][7:0]  rdWord;
    logic [LANES-1:0][7:0]  dbgWord;
    logic [7:0]             rdByte;
    logic [15:0]            rdHalf;
    logic [31:0]            loadData;
    logic                   unusedBits;

    assign wordIdx  = bus.inALUResult[AW+1:2];
    assign byteOff  = bus.inALUResult[1:0];
    assign memRead  = bus.inMEM[1];
    assign memWrite = bus.inMEM[0];

    // Branch bit and the address bits above the memory size play no part here.
    assign unusedBits = ^{bus.inMEM[2], bus.inALUResult[31:AW+2]};

    always_comb begin
        isB      = (bus.inLSType == LS_B) || (bus.inLSType == LS_BU);
        isH      = (bus.inLSType == LS_H) || (bus.inLSType == LS_HU);
        isW      = !isB && !isH;
        isSigned = (bus.inLSType == LS_B) || (bus.inLSType == LS_H);
        misaligned = (memRead || memWrite) &&
                     ((isH && byteOff[0]) || (isW && (byteOff != 2'b00)));
        wrEn = memWrite && !misaligned && !bus.stop_debug;
    end

    // Store data is replicated across lanes so each lane only needs its enable.
    always_comb begin
        byteEn = '0;
        wrData = bus.inRegB;
        if (isB) begin
            byteEn[byteOff] = 1'b1;
            wrData          = {LANES{bus.inRegB[7:0]}};
        end else if (isH) begin
            byteEn = byteOff[1] ? 4'b1100 : 4'b0011;
            wrData = {2{bus.inRegB[15:0]}};
        end else begin
            byteEn = 4'b1111;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gLane
        memory_access_lane #(.DEPTH(DEPTH), .AW(AW)) uLane (
            .clk     (clk),
            .rst     (rst),
            .we      (wrEn && byteEn[g]),
            .idx     (wordIdx),
            .wrData  (wrData[g]),
            .rdData  (rdWord[g]),
            .dbgIdx  (bus.dbg_addr),
            .dbgData (dbgWord[g])
        );
    end

    always_comb begin
        rdByte   = rdWord[byteOff];
        rdHalf   = byteOff[1] ? rdWord[3:2] : rdWord[1:0];
        loadData = rdWord;
        if (isB)      loadData = {{24{isSigned && rdByte[7]}}, rdByte};
        else if (isH) loadData = {{16{isSigned && rdHalf[15]}}, rdHalf};
    end

    // MEM/WB register; a frozen pipeline holds everything.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            bus.outWB         <= '0;
            bus.outALUResult  <= '0;
            bus.outReadData   <= '0;
            bus.outRegF_wreg  <= '0;
            bus.outMisaligned <= 1'b0;
        end else if (!bus.stop_debug) begin
            bus.outWB         <= {bus.inWB[4:1], bus.inWB[0] && !misaligned};
            bus.outALUResult  <= bus.inALUResult;
            bus.outReadData   <= (memRead && !misaligned) ? loadData : 32'h0;
            bus.outRegF_wreg  <= bus.inRegF_wreg;
            bus.outMisaligned <= misaligned;
        end
    end

    assign bus.outRegF_wd  = bus.outWB[1] ? bus.outReadData : bus.outALUResult;
    assign bus.MEM_rd      = bus.inRegF_wreg;
    assign bus.MEM_regF_wr = bus.inWB[0];
    assign bus.dbg_data    = dbgWord;
endmodule
